// File: rtl/sys_throttle_responder.sv
// Receive side of FM_SYS_THROTTLE_N: synchronize, glitch-filter, then hold PROCHOT/MEMHOT
// for a minimum time, with a sticky event flag and a saturating event counter for readout.
module sys_throttle_responder #(
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_CYCLES     = 4,
  parameter int MIN_ASSERT_CYCLES = 1000,
  parameter int CNT_WIDTH         = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iSysThrottle_n,
  input  logic                 iEnable,
  input  logic                 iProchotEn,
  input  logic                 iMemhotEn,
  input  logic                 iClrStatus,
  output logic                 oProchot_n,
  output logic                 oMemhot_n,
  output logic                 oThrottleActive,
  output logic                 oEventLatched,
  output logic [CNT_WIDTH-1:0] oEventCount
);

  // state    | meaning
  // IDLE     | no throttle seen, counters cleared
  // QUALIFY  | synchronized input low, counting consecutive low clocks
  // ASSERTED | throttle qualified, PROCHOT/MEMHOT requested, minimum hold running
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUALIFY  = 2'd1,
    ASSERTED = 2'd2
  } stateT;

  localparam int FILT_W = $clog2(FILTER_CYCLES + 1);
  localparam int HOLD_W = $clog2(MIN_ASSERT_CYCLES + 1);
  localparam logic [FILT_W-1:0]    FILT_LAST = FILT_W'(FILTER_CYCLES);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] syncFf;
  logic                   syncLow;
  stateT                  state, stateNext;
  logic [FILT_W-1:0]      filtCnt, filtNext;
  logic [HOLD_W-1:0]      holdCnt, holdNext;
  logic                   qualEvent;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) syncFf <= '1;
    else         syncFf <= {syncFf[SYNC_STAGES-2:0], iSysThrottle_n};
  end

  assign syncLow = ~syncFf[SYNC_STAGES-1];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      filtCnt <= '0;
      holdCnt <= '0;
    end else begin
      state   <= stateNext;
      filtCnt <= filtNext;
      holdCnt <= holdNext;
    end
  end

  // The hold compare counts the cycle being completed, so the registered
  // outputs (one clock behind state) stay asserted exactly MIN_ASSERT_CYCLES.
  always_comb begin
    stateNext = state;
    filtNext  = filtCnt;
    holdNext  = holdCnt;
    qualEvent = 1'b0;
    if (!iEnable) begin
      stateNext = IDLE;
      filtNext  = '0;
      holdNext  = '0;
    end else begin
      case (state)
        IDLE: begin
          filtNext = '0;
          holdNext = '0;
          if (syncLow) begin
            stateNext = QUALIFY;
            filtNext  = FILT_W'(1);
          end
        end
        QUALIFY: begin
          if (!syncLow) begin
            stateNext = IDLE;
            filtNext  = '0;
          end else if (filtCnt == FILT_LAST) begin
            stateNext = ASSERTED;
            filtNext  = '0;
            holdNext  = '0;
            qualEvent = 1'b1;
          end else begin
            filtNext = filtCnt + FILT_W'(1);
          end
        end
        ASSERTED: begin
          if (holdCnt < HOLD_LAST) holdNext = holdCnt + HOLD_W'(1);
          if ((holdCnt >= HOLD_LAST) && !syncLow) begin
            stateNext = IDLE;
            holdNext  = '0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Disable drops the requests on the same edge that forces IDLE.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oProchot_n      <= 1'b1;
      oMemhot_n       <= 1'b1;
      oThrottleActive <= 1'b0;
    end else begin
      oProchot_n      <= !((state == ASSERTED) && iEnable && iProchotEn);
      oMemhot_n       <= !((state == ASSERTED) && iEnable && iMemhotEn);
      oThrottleActive <= (state == ASSERTED) && iEnable;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oEventLatched <= 1'b0;
      oEventCount   <= '0;
    end else if (qualEvent) begin
      oEventLatched <= 1'b1;
      if (iClrStatus)                oEventCount <= CNT_WIDTH'(1);
      else if (oEventCount != CNT_MAX) oEventCount <= oEventCount + CNT_WIDTH'(1);
    end else if (iClrStatus) begin
      oEventLatched <= 1'b0;
      oEventCount   <= '0;
    end
  end

endmodule

// File: tb/tb_sys_throttle_responder.sv
// Bench for sys_throttle_responder: directed and randomized throttle patterns compared
// every clock against a cycle-level behavioural model of the throttle rules.
module tb_sys_throttle_responder;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int MINA = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          iClk = 1'b0;
  logic          iRst_n, iSysThrottle_n, iEnable, iProchotEn, iMemhotEn, iClrStatus;
  logic          oProchot_n, oMemhot_n, oThrottleActive, oEventLatched;
  logic [CW-1:0] oEventCount;

  int nCompared   = 0;
  int nMismatched = 0;

  // model: input pipeline, consecutive-low run, assertion age, status
  bit mS[SYNC];
  bit mActive, mLatch, mProN, mMemN, mThr;
  int mRun, mAge, mCount;

  sys_throttle_responder #(
    .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .MIN_ASSERT_CYCLES(MINA), .CNT_WIDTH(CW)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iSysThrottle_n(iSysThrottle_n), .iEnable(iEnable),
    .iProchotEn(iProchotEn), .iMemhotEn(iMemhotEn), .iClrStatus(iClrStatus),
    .oProchot_n(oProchot_n), .oMemhot_n(oMemhot_n), .oThrottleActive(oThrottleActive),
    .oEventLatched(oEventLatched), .oEventCount(oEventCount)
  );

  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < SYNC; i++) mS[i] = 1'b1;
    mActive = 0; mRun = 0; mAge = 0; mLatch = 0; mCount = 0;
    mProN = 1; mMemN = 1; mThr = 0;
  endtask

  // true when the coming edge would complete a qualifying low run
  function automatic bit eventNext();
    return !mActive && iEnable && !mS[SYNC-1] && (mRun == FILT);
  endfunction

  task automatic modelStep();
    bit sl, evt;
    sl  = !mS[SYNC-1];
    evt = 0;
    mProN = !(mActive && iEnable && iProchotEn);
    mMemN = !(mActive && iEnable && iMemhotEn);
    mThr  = mActive && iEnable;
    if (!iEnable) begin
      mActive = 0; mRun = 0;
    end else if (mActive) begin
      if (mAge >= MINA && !sl) begin mActive = 0; mRun = 0; end
      else mAge++;
    end else begin
      mRun = sl ? mRun + 1 : 0;
      if (mRun == FILT + 1) begin mActive = 1; mAge = 1; mRun = 0; evt = 1; end
    end
    if (evt) begin
      mLatch = 1;
      mCount = iClrStatus ? 1 : ((mCount < CMAX) ? mCount + 1 : CMAX);
    end else if (iClrStatus) begin
      mLatch = 0; mCount = 0;
    end
    for (int i = SYNC - 1; i > 0; i--) mS[i] = mS[i-1];
    mS[0] = iSysThrottle_n;
  endtask

  task automatic tick();
    @(posedge iClk);
    modelStep();
    @(negedge iClk);
    checkVal("prochot_n", oProchot_n, mProN);
    checkVal("memhot_n", oMemhot_n, mMemN);
    checkVal("throttle_active", oThrottleActive, mThr);
    checkVal("event_latched", oEventLatched, mLatch);
    checkVal("event_count", oEventCount, mCount);
  endtask

  task automatic drive(input bit lvl, input int n);
    iSysThrottle_n = lvl;
    repeat (n) tick();
  endtask

  initial begin
    int lvl, len;
    iRst_n = 0; iSysThrottle_n = 1; iEnable = 1; iProchotEn = 1; iMemhotEn = 1; iClrStatus = 0;
    modelReset();
    repeat (3) @(negedge iClk);
    iRst_n = 1;

    drive(1, 100);
    checkVal("idle_count", oEventCount, 0);
    checkVal("idle_prochot", oProchot_n, 1);

    drive(0, 3); drive(1, 30);
    checkVal("glitch3_count", oEventCount, 0);
    drive(0, 4); drive(1, 30);
    checkVal("glitch4_count", oEventCount, 0);
    drive(0, 5); drive(1, 30);
    checkVal("pass5_count", oEventCount, 1);

    drive(0, 20); drive(1, 30);
    checkVal("long_low_count", oEventCount, 2);
    drive(0, 6); drive(1, 30);
    checkVal("min_hold_count", oEventCount, 3);

    iMemhotEn = 0;
    drive(0, 12);
    checkVal("memhot_masked", oMemhot_n, 1);
    checkVal("prochot_on", oProchot_n, 0);
    iMemhotEn = 1;
    drive(1, 30);

    drive(0, 12);
    iEnable = 0;
    tick();
    checkVal("disable_prochot", oProchot_n, 1);
    checkVal("disable_memhot", oMemhot_n, 1);
    checkVal("disable_count", oEventCount, 5);
    repeat (2) tick();
    iEnable = 1;
    drive(0, 20);
    checkVal("requal_count", oEventCount, 6);
    drive(1, 30);

    for (int r = 0; r < 60; r++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 24);
      iSysThrottle_n = lvl[0];
      for (int k = 0; k < len; k++) begin
        iEnable    = ($urandom_range(0, 29) != 0);
        iProchotEn = ($urandom_range(0, 7) != 0);
        iMemhotEn  = ($urandom_range(0, 7) != 0);
        iClrStatus = ($urandom_range(0, 19) == 0);
        tick();
      end
    end
    iEnable = 1; iProchotEn = 1; iMemhotEn = 1; iClrStatus = 0;
    drive(1, 30);

    for (int e = 0; e < 260; e++) begin
      drive(0, 6); drive(1, 20);
    end
    checkVal("sat_count", oEventCount, CMAX);

    iSysThrottle_n = 0;
    for (int k = 0; k < 12; k++) begin
      iClrStatus = eventNext();
      tick();
    end
    iClrStatus = 0;
    checkVal("clr_vs_event_count", oEventCount, 1);
    checkVal("clr_vs_event_latch", oEventLatched, 1);
    drive(1, 30);

    drive(0, 10);
    checkVal("pre_reset_prochot", oProchot_n, 0);
    iRst_n = 0;
    #1;
    checkVal("rst_prochot", oProchot_n, 1);
    checkVal("rst_memhot", oMemhot_n, 1);
    checkVal("rst_active", oThrottleActive, 0);
    checkVal("rst_count", oEventCount, 0);
    checkVal("rst_latch", oEventLatched, 0);
    modelReset();
    iSysThrottle_n = 1;
    repeat (2) @(negedge iClk);
    iRst_n = 1;
    drive(1, 10);
    drive(0, 8);
    iClrStatus = 1;
    drive(1, 1);
    iClrStatus = 0;
    drive(1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
